// File: rtl/me_pkg.sv
// ============================================================================
// Module   : me_pkg
// Purpose  : Shared types and constants for the motion-estimation PE scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package me_pkg;
  localparam int PIXEL = 8;

  localparam logic [1:0] REF_UP1 = 2'b00;
  localparam logic [1:0] REF_UP8 = 2'b01;
  localparam logic [1:0] REF_DN1 = 2'b10;
  localparam logic [1:0] REF_DN8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FILL   = 3'd2,
    ST_SEARCH = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
endpackage

`default_nettype wire

// File: rtl/snake_walker.sv
// ============================================================================
// Module   : snake_walker
// Purpose  : Candidate position counters and reference move code for a
//            column-wise snake walk over the search window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_walker
  import me_pkg::*;
#(
  parameter int SR_W = 16,
  parameter int SR_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(SR_W)-1:0]   cand_x,
  output logic [$clog2(SR_H)-1:0]   cand_y,
  output logic [1:0]                move_code,
  output logic                      last_cand
);
  localparam int XW = $clog2(SR_W);
  localparam int YW = $clog2(SR_H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          col_odd, last_row;

  // Even columns walk down, odd columns walk up.
  assign col_odd   = x_q[0];
  assign last_row  = col_odd ? (y_q == '0) : (y_q == YW'(SR_H - 1));
  assign last_cand = last_row && (x_q == XW'(SR_W - 1));
  assign move_code = last_row ? REF_UP8 : (col_odd ? REF_UP1 : REF_DN1);
  assign cand_x    = x_q;
  assign cand_y    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance && !last_cand) begin
      if (last_row) x_d = x_q + XW'(1);
      else if (col_odd) y_d = y_q - YW'(1);
      else y_d = y_q + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/pe_array_sched.sv
// ============================================================================
// Module   : pe_array_sched
// Purpose  : Load / fill / snake-search sequencer for the 8x8 PE systolic
//            array. Optional search-time preload: PE_SCHED_PRELOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_sched
  import me_pkg::*;
#(
  parameter int BLK  = 8,
  parameter int SR_W = 16,
  parameter int SR_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      curr_valid,
  output logic                      curr_ready,
  input  logic                      ref_valid,
  output logic                      ref_ready,
  output logic                      in_curr_enable,
  output logic                      cb_select,
  output logic [1:0]                abs_control,
  output logic                      change_ref,
  output logic [1:0]                ref_input_control,
  output logic                      sad_valid,
  output logic                      sad_cb,
  output logic [$clog2(SR_W)-1:0]   cand_x,
  output logic [$clog2(SR_H)-1:0]   cand_y
);
  localparam int             CW       = $clog2(BLK + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLK - 1);

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic          hold_q, hold_d;
  logic          pair_q, pair_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_search, ref_acc, cand_done, walk_clear, last_cand;
  logic [1:0]    move_code;
`ifdef PE_SCHED_PRELOAD_EN
  localparam logic [CW-1:0]  CNT_FULL = CW'(BLK);
  logic          pend_q, pend_d;
`endif

  assign in_search = (state_q == ST_SEARCH);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cb_select = pair_q;
  assign ref_ready = (state_q == ST_FILL) || (in_search && phase_q && !last_cand);
`ifdef PE_SCHED_PRELOAD_EN
  // Preload beats target the idle pair while the active pair is searched.
  assign curr_ready = (state_q == ST_LOAD) || (in_search && pend_q && (cnt_q != CNT_FULL));
`else
  assign curr_ready = (state_q == ST_LOAD);
`endif
  assign in_curr_enable = curr_valid & curr_ready;
  assign ref_acc        = ref_valid & ref_ready;
  assign change_ref     = ref_acc;
  assign cand_done      = in_search && phase_q && (ref_acc || last_cand);
  assign walk_clear     = (state_q == ST_FILL) && ref_acc && (cnt_q == CNT_LAST);

  // A stalled phase 1 repeats the same abs_out set, so only its first cycle counts.
  assign sad_valid   = in_search && !hold_q;
  assign sad_cb      = in_search && phase_q;
  assign abs_control = in_search ? {pair_q, phase_q} : 2'b00;

  always_comb begin
    ref_input_control = REF_UP1;
    if (state_q == ST_FILL) ref_input_control = REF_DN1;
    else if (in_search && phase_q) ref_input_control = move_code;
  end

  snake_walker #(.SR_W(SR_W), .SR_H(SR_H)) u_walker (
    .clk       (clk),
    .rst       (rst),
    .clear     (walk_clear),
    .advance   (cand_done),
    .cand_x    (cand_x),
    .cand_y    (cand_y),
    .move_code (move_code),
    .last_cand (last_cand)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hold_d  = 1'b0;
    pair_d  = pair_q;
    cnt_d   = cnt_q;
`ifdef PE_SCHED_PRELOAD_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_curr_enable) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_FILL: begin
        if (ref_acc) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
            pair_d  = ~pair_q;
            phase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_SEARCH: begin
`ifdef PE_SCHED_PRELOAD_EN
        if (start) pend_d = 1'b1;
        if (in_curr_enable) cnt_d = cnt_q + CW'(1);
`endif
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (cand_done) begin
          phase_d = 1'b0;
          if (last_cand) state_d = ST_DONE;
        end else begin
          hold_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef PE_SCHED_PRELOAD_EN
        if (pend_q) begin
          pend_d = 1'b0;
          if (cnt_q == CNT_FULL) begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end else begin
            // Preload not finished: resume the count in LOAD.
            state_d = ST_LOAD;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      hold_q  <= 1'b0;
      pair_q  <= 1'b1;
      cnt_q   <= '0;
`ifdef PE_SCHED_PRELOAD_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
`ifdef PE_SCHED_PRELOAD_EN
      pend_q  <= pend_d;
`endif
    end
  end
endmodule

`default_nettype wire
